regfile_2r1w_sb: RTL and testbench
==================================

Name: regfile_2r1w_sb

Overview:
- Parametrised next-generation CPU register file: two independent combinational read ports and one synchronous write port.
- Optional write-to-read bypass and optional hardwired-zero register 0.
- Per-register busy scoreboard: the decode stage marks a destination busy at issue; writeback clears it.
- Sits between decode (read ports, busy query/set) and writeback (write port).

Parameters:
- N_REGS, 8, number of architectural registers (2..256, need not be a power of two).
- REG_WIDTH, 8, data width in bits.
- ADDR_WIDTH, $clog2(N_REGS), index width (minimum 1).
- ZERO_REG, 0, 1 = register 0 reads as zero, ignores writes and never becomes busy.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- write_enable  input  1  write strobe.
- wreg_index  input  ADDR_WIDTH  write register index.
- data_in  input  REG_WIDTH  write data.
- rreg_a_index  input  ADDR_WIDTH  read port A index.
- data_out_a  output  REG_WIDTH  read port A data.
- rreg_b_index  input  ADDR_WIDTH  read port B index.
- data_out_b  output  REG_WIDTH  read port B data.
- busy_set  input  1  mark busy_set_index busy.
- busy_set_index  input  ADDR_WIDTH  register to mark busy.
- busy_a  output  1  scoreboard bit for rreg_a_index.
- busy_b  output  1  scoreboard bit for rreg_b_index.
- any_busy  output  1  OR of all busy bits (registered view).

Behaviour:
- Reset:
  - reset_n low asynchronously clears every register and busy bit to 0, regardless of clk.
  - While held low, data_out_a/b = 0 (unless bypass applies), busy_a/b = 0, any_busy = 0, and writes and busy_set are ignored.
  - Deassertion takes effect at the next rising edge.
- Write: on rising edge with write_enable = 1, regs[wreg_index] <= data_in.
- Read: purely combinational, zero latency; data_out_x = regs[rreg_x_index].
- Bypass (BYPASS = 1):
  - When write_enable = 1 and wreg_index == rreg_x_index, data_out_x = data_in in the same cycle.
  - Both ports may bypass simultaneously.
  - With BYPASS = 0, the read returns the old value and the new value appears the cycle after the edge.
- Zero register (ZERO_REG = 1):
  - Index 0 reads 0 on both ports, with no bypass.
  - Writes to index 0 are dropped; busy_set to index 0 is dropped; busy of index 0 is always 0.
- Out-of-range index (>= N_REGS):
  - Writes and busy_set are dropped.
  - Reads return 0; busy returns 0; no bypass.
- Scoreboard:
  - Rising edge with busy_set = 1: busy[busy_set_index] <= 1.
  - Rising edge with write_enable = 1: busy[wreg_index] <= 0.
  - Same index set and cleared in the same edge: set wins, final busy = 1 (back-to-back reissue).
  - Different indices: both take effect.
  - Setting an already-busy register leaves it busy.
  - Clearing a non-busy register is harmless.
- Busy query:
  - busy_x = busy[rreg_x_index], combinational.
  - If BYPASS = 1 and a same-cycle write targets rreg_x_index, busy_x = 0 (data forwarded that cycle).
  - The busy_set input never affects busy_x in the same cycle; a set becomes visible the cycle after the edge.
- any_busy reflects stored busy bits only (post-edge state); no same-cycle forwarding.
- No internal FSM beyond the register and busy arrays; all outputs are a function of state plus current inputs as above.

Test Plan:
- Reset: write 0xAA to r3, assert reset_n = 0 mid-cycle, no clock edge -> data_out_a (index 3) = 0x00 immediately; any_busy = 0.
- Dual read: write r1 = 0x11 and r2 = 0x22 on consecutive edges, then rreg_a = 1, rreg_b = 2 -> data_out_a = 0x11, data_out_b = 0x22 with no added latency.
- Bypass, BYPASS = 1: r5 = 0x05 stored; write_enable = 1, wreg_index = 5, data_in = 0x5A, both read indices = 5 -> data_out_a = data_out_b = 0x5A before the edge.
  - Same stimulus with BYPASS = 0 -> both read 0x05 before the edge and 0x5A after it.
- Zero register, ZERO_REG = 1: write 0xFF to r0 and busy_set r0 -> data_out_a (index 0) = 0x00, busy_a = 0, any_busy = 0.
- Scoreboard sequence:
  - busy_set r4 at edge 1 -> busy_a (index 4) = 1 and any_busy = 1 from edge 1.
  - Write r4 = 0x44 at edge 3 -> during that cycle busy_a = 0 and data_out_a = 0x44; after edge 3 busy bit = 0, any_busy = 0.
- Simultaneous set and clear: busy[6] = 1; at one edge busy_set r6 and write r6 = 0x66 -> after the edge busy[6] = 1 and regs[6] = 0x66.
  - With N_REGS = 6, a write to index 7 is ignored and reading index 7 returns 0.

Source files
------------

// File: rtl/regfile_2r1w_sb_if.sv
// Decode/writeback bundle for the 2-read/1-write register file with busy scoreboard.
// master = pipeline side driving indices and write data, slave = register file.
interface regfile_2r1w_sb_if #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned REG_WIDTH  = 8
);
  logic                  write_enable;
  logic [ADDR_WIDTH-1:0] wreg_index;
  logic [REG_WIDTH-1:0]  data_in;
  logic [ADDR_WIDTH-1:0] rreg_a_index;
  logic [REG_WIDTH-1:0]  data_out_a;
  logic [ADDR_WIDTH-1:0] rreg_b_index;
  logic [REG_WIDTH-1:0]  data_out_b;
  logic                  busy_set;
  logic [ADDR_WIDTH-1:0] busy_set_index;
  logic                  busy_a;
  logic                  busy_b;
  logic                  any_busy;

  modport master (
    output write_enable, wreg_index, data_in, rreg_a_index, rreg_b_index,
           busy_set, busy_set_index,
    input  data_out_a, data_out_b, busy_a, busy_b, any_busy
  );

  modport slave (
    input  write_enable, wreg_index, data_in, rreg_a_index, rreg_b_index,
           busy_set, busy_set_index,
    output data_out_a, data_out_b, busy_a, busy_b, any_busy
  );
endinterface

// File: rtl/regfile_2r1w_sb.sv
// Register file: two combinational read ports, one synchronous write port,
// optional write-to-read bypass, optional hardwired r0 and a per-register busy scoreboard.
module regfile_2r1w_sb #(
  parameter int unsigned N_REGS     = 8,
  parameter int unsigned REG_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = (N_REGS > 2) ? $clog2(N_REGS) : 1,
  parameter int unsigned ZERO_REG   = 0,
  parameter int unsigned BYPASS     = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  regfile_2r1w_sb_if.slave   bus
);

  localparam int unsigned N_PORTS = 2;

  logic [REG_WIDTH-1:0]  r_regs [N_REGS];
  logic [N_REGS-1:0]     r_busy;
  logic [N_REGS-1:0]     w_busy_nxt;
  logic                  w_wr_ok;
  logic                  w_set_ok;
  logic [ADDR_WIDTH-1:0] w_rd_idx  [N_PORTS];
  logic [REG_WIDTH-1:0]  w_rd_data [N_PORTS];
  logic                  w_rd_busy [N_PORTS];

  // An index is live when it exists and is not the hardwired zero register.
  function automatic logic idx_live(input logic [ADDR_WIDTH-1:0] idx);
    return (32'(idx) < N_REGS) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  assign w_wr_ok  = bus.write_enable && idx_live(bus.wreg_index);
  assign w_set_ok = bus.busy_set && idx_live(bus.busy_set_index);

  // Writeback clears, issue sets; set applied last so a back-to-back reissue stays busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok)  w_busy_nxt[bus.wreg_index]     = 1'b0;
    if (w_set_ok) w_busy_nxt[bus.busy_set_index] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
      for (int i = 0; i < int'(N_REGS); i++) r_regs[i] <= '0;
    end else begin
      if (w_wr_ok) r_regs[bus.wreg_index] <= bus.data_in;
      r_busy <= w_busy_nxt;
    end
  end

  assign w_rd_idx[0] = bus.rreg_a_index;
  assign w_rd_idx[1] = bus.rreg_b_index;

  // Read path: dead indices read zero/not-busy; a live same-cycle write forwards and hides busy.
  always_comb begin
    for (int p = 0; p < int'(N_PORTS); p++) begin
      w_rd_data[p] = '0;
      w_rd_busy[p] = 1'b0;
      if (idx_live(w_rd_idx[p])) begin
        if ((BYPASS != 0) && bus.write_enable && (bus.wreg_index == w_rd_idx[p])) begin
          w_rd_data[p] = bus.data_in;
        end else begin
          w_rd_data[p] = r_regs[w_rd_idx[p]];
          w_rd_busy[p] = r_busy[w_rd_idx[p]];
        end
      end
    end
  end

  assign bus.data_out_a = w_rd_data[0];
  assign bus.data_out_b = w_rd_data[1];
  assign bus.busy_a     = w_rd_busy[0];
  assign bus.busy_b     = w_rd_busy[1];
  assign bus.any_busy   = |r_busy;

endmodule

// File: tb/tb_regfile_2r1w_sb.sv
// Bench for regfile_2r1w_sb: two configurations (8 regs/bypass, 6 regs/zero-reg/no-bypass)
// driven by shared directed then random stimulus and checked against an array model.
module tb_regfile_2r1w_sb;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       we;
  logic [2:0] widx;
  logic [7:0] din;
  logic [2:0] ra;
  logic [2:0] rb;
  logic       bs;
  logic [2:0] bsi;

  always #5 clk = ~clk;

  regfile_2r1w_sb_if #(.ADDR_WIDTH(3), .REG_WIDTH(8)) bus0 ();
  regfile_2r1w_sb_if #(.ADDR_WIDTH(3), .REG_WIDTH(8)) bus1 ();

  assign bus0.write_enable = we;   assign bus1.write_enable = we;
  assign bus0.wreg_index   = widx; assign bus1.wreg_index   = widx;
  assign bus0.data_in      = din;  assign bus1.data_in      = din;
  assign bus0.rreg_a_index = ra;   assign bus1.rreg_a_index = ra;
  assign bus0.rreg_b_index = rb;   assign bus1.rreg_b_index = rb;
  assign bus0.busy_set     = bs;   assign bus1.busy_set     = bs;
  assign bus0.busy_set_index = bsi; assign bus1.busy_set_index = bsi;

  regfile_2r1w_sb #(.N_REGS(8), .REG_WIDTH(8), .ZERO_REG(0), .BYPASS(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0));
  regfile_2r1w_sb #(.N_REGS(6), .REG_WIDTH(8), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));

  logic [7:0] o_da [2];
  logic [7:0] o_db [2];
  logic       o_ba [2];
  logic       o_bb [2];
  logic       o_any[2];
  assign o_da[0] = bus0.data_out_a; assign o_da[1] = bus1.data_out_a;
  assign o_db[0] = bus0.data_out_b; assign o_db[1] = bus1.data_out_b;
  assign o_ba[0] = bus0.busy_a;     assign o_ba[1] = bus1.busy_a;
  assign o_bb[0] = bus0.busy_b;     assign o_bb[1] = bus1.busy_b;
  assign o_any[0] = bus0.any_busy;  assign o_any[1] = bus1.any_busy;

  // Reference model: configuration table plus plain register/busy arrays.
  int         cfg_n    [2] = '{8, 6};
  bit         cfg_zero [2] = '{1'b0, 1'b1};
  bit         cfg_byp  [2] = '{1'b1, 1'b0};
  logic [7:0] m_regs [2][8];
  bit         m_busy [2][8];
  int         errors = 0;
  int         checks = 0;

  function automatic bit live(int c, int idx);
    return (idx < cfg_n[c]) && !(cfg_zero[c] && idx == 0);
  endfunction

  function automatic bit fwd(int c, int idx);
    return cfg_byp[c] && we && (int'(widx) == idx);
  endfunction

  function automatic logic [7:0] exp_data(int c, int idx);
    if (!live(c, idx)) return 8'h00;
    if (fwd(c, idx))   return din;
    return m_regs[c][idx];
  endfunction

  function automatic logic [7:0] exp_busy(int c, int idx);
    if (!live(c, idx) || fwd(c, idx)) return 8'h00;
    return 8'(m_busy[c][idx]);
  endfunction

  function automatic logic [7:0] exp_any(int c);
    bit a = 1'b0;
    for (int i = 0; i < 8; i++) a |= m_busy[c][i];
    return 8'(a);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 8; i++) begin
        m_regs[c][i] = 8'h00;
        m_busy[c][i] = 1'b0;
      end
  endtask

  task automatic model_edge();
    if (reset_n) begin
      for (int c = 0; c < 2; c++) begin
        if (we && live(c, int'(widx))) begin
          m_regs[c][widx] = din;
          m_busy[c][widx] = 1'b0;
        end
        if (bs && live(c, int'(bsi))) m_busy[c][bsi] = 1'b1;
      end
    end
  endtask

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string step);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("%s/c%0d/data_a", step, c), o_da[c], exp_data(c, int'(ra)));
      check($sformatf("%s/c%0d/data_b", step, c), o_db[c], exp_data(c, int'(rb)));
      check($sformatf("%s/c%0d/busy_a", step, c), 8'(o_ba[c]), exp_busy(c, int'(ra)));
      check($sformatf("%s/c%0d/busy_b", step, c), 8'(o_bb[c]), exp_busy(c, int'(rb)));
      check($sformatf("%s/c%0d/any", step, c), 8'(o_any[c]), exp_any(c));
    end
  endtask

  task automatic drive(bit we_, int widx_, int din_, int ra_, int rb_, bit bs_, int bsi_);
    we   = we_;
    widx = 3'(widx_);
    din  = 8'(din_);
    ra   = 3'(ra_);
    rb   = 3'(rb_);
    bs   = bs_;
    bsi  = 3'(bsi_);
  endtask

  task automatic settle(string step);
    #2;
    check_all(step);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step(string tag, bit we_, int widx_, int din_, int ra_, int rb_, bit bs_, int bsi_);
    drive(we_, widx_, din_, ra_, rb_, bs_, bsi_);
    settle(tag);
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 1'b0, 0);
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;
    tick();

    // Asynchronous reset clears a stored value without a clock edge.
    step("wr_r3", 1'b1, 3, 'hAA, 3, 3, 1'b1, 3);
    drive(1'b0, 0, 0, 3, 3, 1'b0, 0);
    #2;
    check("pre_rst/c0/data_a", o_da[0], 8'hAA);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst/c0/data_a", o_da[0], 8'h00);
    check("async_rst/c0/any", 8'(o_any[0]), 8'h00);
    check_all("async_rst");
    tick();
    step("rst_hold", 1'b1, 3, 'h77, 3, 2, 1'b1, 2);
    reset_n = 1'b1;
    step("post_rst", 1'b0, 0, 0, 3, 2, 1'b0, 0);

    // Dual read.
    step("wr_r1", 1'b1, 1, 'h11, 0, 0, 1'b0, 0);
    step("wr_r2", 1'b1, 2, 'h22, 0, 0, 1'b0, 0);
    drive(1'b0, 0, 0, 1, 2, 1'b0, 0);
    settle("dual_rd");
    check("dual_rd/c0/a", o_da[0], 8'h11);
    check("dual_rd/c0/b", o_db[0], 8'h22);
    tick();

    // Bypass versus no bypass.
    step("wr_r5", 1'b1, 5, 'h05, 0, 0, 1'b0, 0);
    drive(1'b1, 5, 'h5A, 5, 5, 1'b0, 0);
    settle("byp");
    check("byp/c0/a", o_da[0], 8'h5A);
    check("byp/c0/b", o_db[0], 8'h5A);
    check("nobyp/c1/a", o_da[1], 8'h05);
    check("nobyp/c1/b", o_db[1], 8'h05);
    tick();
    drive(1'b0, 0, 0, 5, 5, 1'b0, 0);
    settle("nobyp_after");
    check("nobyp_after/c1/a", o_da[1], 8'h5A);
    tick();

    // Zero register on the 6-register instance.
    step("zero_wr", 1'b1, 0, 'hFF, 0, 0, 1'b1, 0);
    drive(1'b0, 0, 0, 0, 0, 1'b0, 0);
    settle("zero_rd");
    check("zero_rd/c1/a", o_da[1], 8'h00);
    check("zero_rd/c1/busy_a", 8'(o_ba[1]), 8'h00);
    check("zero_rd/c1/any", 8'(o_any[1]), 8'h00);
    tick();
    step("clr_r0", 1'b1, 0, 'h00, 0, 0, 1'b0, 0);

    // Scoreboard set then writeback clear.
    step("sb_set", 1'b0, 0, 0, 4, 4, 1'b1, 4);
    drive(1'b0, 0, 0, 4, 4, 1'b0, 0);
    settle("sb_busy");
    check("sb_busy/c0/busy_a", 8'(o_ba[0]), 8'h01);
    check("sb_busy/c0/any", 8'(o_any[0]), 8'h01);
    tick();
    drive(1'b1, 4, 'h44, 4, 4, 1'b0, 0);
    settle("sb_wb");
    check("sb_wb/c0/busy_a", 8'(o_ba[0]), 8'h00);
    check("sb_wb/c0/data_a", o_da[0], 8'h44);
    tick();
    drive(1'b0, 0, 0, 4, 4, 1'b0, 0);
    settle("sb_done");
    check("sb_done/c0/any", 8'(o_any[0]), 8'h00);
    tick();

    // Same-edge set and clear: set wins.
    step("sc_set", 1'b0, 0, 0, 6, 6, 1'b1, 6);
    step("sc_both", 1'b1, 6, 'h66, 6, 6, 1'b1, 6);
    drive(1'b0, 0, 0, 6, 6, 1'b0, 0);
    settle("sc_after");
    check("sc_after/c0/busy_a", 8'(o_ba[0]), 8'h01);
    check("sc_after/c0/data_a", o_da[0], 8'h66);
    check("sc_after/c1/data_a", o_da[1], 8'h00);
    tick();

    // Out-of-range write on the 6-register instance.
    step("oor_wr", 1'b1, 7, 'h77, 7, 7, 1'b1, 7);
    drive(1'b0, 0, 0, 7, 7, 1'b0, 0);
    settle("oor_rd");
    check("oor_rd/c1/data_a", o_da[1], 8'h00);
    check("oor_rd/c0/data_a", o_da[0], 8'h77);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
